// File: rtl/mnist_pixel_feeder.sv
// Purpose : holds one image and plays it into the recogniser (reset, gap, one pixel per
//           clock), then latches the recogniser's decision and the frame latency.
// Latency : start accepted -> RST_CYCLES reset + GAP_CYCLES gap + IMG_SIZE pixels, then wait for finish.
// Backpressure: none; start is ignored while busy, and buffer writes while busy are dropped.
// Ports   : clk/rst_n (async active-low); wr_en/wr_addr/wr_data image load port;
//           start/busy frame control; rec_rst_n/rec_data_in/rec_finish/rec_decision recogniser
//           side; result/result_valid/cycles/timeout_err frame outcome.
// Option  : define FEEDER_TIMEOUT_EN to abort WAIT_FIN after TIMEOUT_CYCLES cycles without finish.
module mnist_pixel_feeder #(
  parameter int IMG_SIZE       = 784,
  parameter int ADDR_W         = 10,
  parameter int RST_CYCLES     = 5,
  parameter int GAP_CYCLES     = 5,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              start,
  output logic              busy,
  output logic              rec_rst_n,
  output logic [7:0]        rec_data_in,
  input  logic              rec_finish,
  input  logic [3:0]        rec_decision,
  output logic [3:0]        result,
  output logic              result_valid,
  output logic [31:0]       cycles,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_GAP, S_STREAM, S_WAIT_FIN, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_mem [IMG_SIZE];
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [15:0]       r_ph_cnt;
  logic              r_busy;
  logic              r_rec_rst_n;
  logic [7:0]        r_rec_data;
  logic              r_fin_prev;
  logic [3:0]        r_result;
  logic              r_result_vld;
  logic [31:0]       r_cycles;
  logic              w_fin_edge;
  logic              w_accept;
  logic              w_load;
  logic              w_to_hit;

  // The edge detector runs in every state, so a finish held high since
  // STREAM never looks like a new edge once WAIT_FIN is reached.
  assign w_fin_edge = rec_finish & ~r_fin_prev;
  assign w_accept   = (r_state == S_IDLE) && start;

`ifdef FEEDER_TIMEOUT_EN
  logic [31:0] r_to_cnt;
  logic        r_timeout_err;

  assign w_to_hit = (r_state == S_WAIT_FIN) && !w_fin_edge &&
                    (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_WAIT_FIN) r_to_cnt <= r_to_cnt + 32'd1;
      else                       r_to_cnt <= '0;
      if (w_accept)      r_timeout_err <= 1'b0;
      else if (w_to_hit) r_timeout_err <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_to_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_RST;
      S_RST:      if (r_ph_cnt == 16'(RST_CYCLES - 1)) w_next = S_GAP;
      S_GAP:      if (r_ph_cnt == 16'(GAP_CYCLES - 1)) w_next = S_STREAM;
      S_STREAM:   if (r_idx == ADDR_W'(IMG_SIZE - 1)) w_next = S_WAIT_FIN;
      S_WAIT_FIN: if (w_fin_edge || w_to_hit) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Pixel fetch runs one step ahead: the GAP->STREAM edge loads pixel 0, so
  // the first STREAM cycle already shows mem[0] and there are no bubbles.
  assign w_rd_idx = (r_state == S_STREAM) ? r_idx + 1'b1 : '0;
  assign w_load   = (w_next == S_STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ph_cnt     <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_rec_rst_n  <= 1'b0;
      r_rec_data   <= '0;
      r_fin_prev   <= 1'b0;
      r_result     <= '0;
      r_result_vld <= 1'b0;
      r_cycles     <= '0;
    end else begin
      r_state    <= w_next;
      r_fin_prev <= rec_finish;
      // Registered from the next state so rec_rst_n is glitch-free.
      r_rec_rst_n <= (w_next == S_GAP) || (w_next == S_STREAM) ||
                     (w_next == S_WAIT_FIN) || (w_next == S_DONE);

      if ((w_next != r_state) || !((r_state == S_RST) || (r_state == S_GAP)))
        r_ph_cnt <= '0;
      else
        r_ph_cnt <= r_ph_cnt + 16'd1;

      if (w_accept)               r_busy <= 1'b1;
      else if (r_state == S_DONE) r_busy <= 1'b0;

      if (w_load) begin
        r_idx      <= w_rd_idx;
        r_rec_data <= r_mem[w_rd_idx];
      end else if (r_state == S_DONE) begin
        r_rec_data <= '0;
      end

      r_result_vld <= (r_state == S_WAIT_FIN) && w_fin_edge;
      if ((r_state == S_WAIT_FIN) && w_fin_edge) r_result <= rec_decision;

      if (w_accept)
        r_cycles <= '0;
      else if (((r_state == S_STREAM) || (r_state == S_WAIT_FIN)) && (r_cycles != '1))
        r_cycles <= r_cycles + 32'd1;
    end
  end

  // Image buffer keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en && !r_busy && (wr_addr < ADDR_W'(IMG_SIZE)))
      r_mem[wr_addr] <= wr_data;
  end

  assign busy         = r_busy;
  assign rec_rst_n    = r_rec_rst_n;
  assign rec_data_in  = r_rec_data;
  assign result       = r_result;
  assign result_valid = r_result_vld;
  assign cycles       = r_cycles;

endmodule

// File: tb/tb_mnist_pixel_feeder.sv
// Bench for mnist_pixel_feeder: a reference image and result queue are kept here; monitors pop
// expected pixels and results as the feeder presents them. Define FEEDER_TIMEOUT_EN to also
// exercise the WAIT_FIN abort path.
module tb_mnist_pixel_feeder;
  localparam int IMG  = 784;
  localparam int RSTC = 5;
  localparam int GAPC = 5;
`ifdef FEEDER_TIMEOUT_EN
  localparam int TOC = 64;
  localparam int W1  = 40;
`else
  localparam int TOC = 65536;
  localparam int W1  = 100;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        rec_rst_n;
  logic [7:0]  rec_data_in;
  logic        rec_finish = 1'b0;
  logic [3:0]  rec_decision = '0;
  logic [3:0]  result;
  logic        result_valid;
  logic [31:0] cycles;
  logic        timeout_err;

  mnist_pixel_feeder #(
    .IMG_SIZE(IMG), .ADDR_W(10), .RST_CYCLES(RSTC), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .rec_rst_n(rec_rst_n), .rec_data_in(rec_data_in),
    .rec_finish(rec_finish), .rec_decision(rec_decision), .result(result),
    .result_valid(result_valid), .cycles(cycles), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [IMG];
  logic [7:0]  pix_q [$];
  logic [35:0] exp_q [$];
  logic [3:0]  m_result = '0;
  logic [31:0] m_cycles = '0;
  bit          m_cyc_known = 1'b1;
  bit          m_to_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pixel monitor: pixel k is due GAPC+k cycles after rec_rst_n rises.
  int         hi_cnt = 0;
  logic [7:0] last_pix = '0;
  always @(negedge clk) begin
    if (rec_rst_n !== 1'b1) begin
      hi_cnt = 0;
    end else begin
      if (hi_cnt < GAPC) begin
        chk("gap_data", rec_data_in, 8'h00);
      end else if (hi_cnt < GAPC + IMG) begin
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_unexpected: got 0x%0h with no pixel pending", rec_data_in);
        end else begin
          last_pix = pix_q.pop_front();
          chk("pixel", rec_data_in, last_pix);
        end
      end else begin
        chk("hold_data", rec_data_in, last_pix);
      end
      hi_cnt++;
    end
  end

  // Result monitor: every result_valid pulse must match a queued expectation.
  always @(negedge clk) begin : mon_res
    logic [35:0] e;
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("result_valid_unexpected", result_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e[35:32]);
        chk("cycles", cycles, e[31:0]);
      end
    end
  end

  task automatic host_write(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 10'(a);
    wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
    if (a < IMG) ref_mem[a] = 8'(d);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rec_rst_n"}, rec_rst_n, 1'b0);
    chk({tag, "_rec_data_in"}, rec_data_in, 8'h00);
    chk({tag, "_result_valid"}, result_valid, 1'b0);
    chk({tag, "_result"}, result, m_result);
    if (m_cyc_known) chk({tag, "_cycles_hold"}, cycles, m_cycles);
    chk({tag, "_timeout_err"}, timeout_err, m_to_err);
  endtask

  // Called at the negedge of an IDLE cycle; returns at the first RST cycle.
  task automatic start_frame();
    start = 1'b1;
    for (int i = 0; i < IMG; i++) pix_q.push_back(ref_mem[i]);
    @(negedge clk);
    start = 1'b0;
    m_to_err = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("cycles_cleared", cycles, 32'd0);
    chk("rec_rst_n_low", rec_rst_n, 1'b0);
    chk("timeout_cleared", timeout_err, 1'b0);
  endtask

  // Recogniser-side model for one frame. rise_w: WAIT_FIN cycle on which finish rises
  // (negative: never). Returns at the DONE cycle, or after recovering from a mid-frame reset.
  task automatic run_body(input int rise_w, input int dec_val, input bit hold_hi,
                          input int drop_w, input bit wr_busy, input int rst_pix,
                          input int pulse_pix);
    int         n;
    int         wmax;
    logic [3:0] dec;
    n = 0;
    while (rec_rst_n !== 1'b1 && n < 50) begin
      n++;
      rec_decision = 4'($urandom);
      @(negedge clk);
    end
    chk("rst_low_cycles", n, RSTC);
    if (hold_hi) rec_finish = 1'b1;
    for (int c = 0; c < GAPC + IMG - 1; c++) begin
      rec_decision = 4'($urandom);
      if (pulse_pix >= 0 && c == GAPC + pulse_pix) rec_finish = 1'b1;
      if (pulse_pix >= 0 && c == GAPC + pulse_pix + 3) rec_finish = 1'b0;
      if (rst_pix >= 0 && c == GAPC + rst_pix) begin
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rec_rst_n", rec_rst_n, 1'b0);
        chk("midrst_rec_data_in", rec_data_in, 8'h00);
        chk("midrst_cycles", cycles, 32'd0);
        chk("midrst_result", result, 4'h0);
        chk("midrst_result_valid", result_valid, 1'b0);
        chk("midrst_timeout_err", timeout_err, 1'b0);
        pix_q.delete();
        m_result = '0;
        m_cycles = '0;
        m_cyc_known = 1'b1;
        m_to_err = 1'b0;
        rec_finish = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    // Now on the last pixel cycle.
    wmax = (rise_w >= 0) ? rise_w : TOC - 1;
    dec = 4'(dec_val);
    for (int w = 0; w <= wmax; w++) begin
      @(negedge clk);
      wr_en = 1'b0;
      rec_decision = 4'($urandom);
      if (wr_busy && w == 2) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 8'hAA;
      end
      if (hold_hi && w == drop_w) rec_finish = 1'b0;
      if (w == rise_w) begin
        if (dec_val < 0) dec = 4'($urandom);
        rec_decision = dec;
        rec_finish = 1'b1;
        exp_q.push_back({dec, 32'(IMG + w + 1)});
        m_result = dec;
        m_cycles = 32'(IMG + w + 1);
        m_cyc_known = 1'b1;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    rec_finish = 1'b0;
    rec_decision = 4'($urandom);
    chk("busy_in_done", busy, 1'b1);
    chk("rec_rst_n_in_done", rec_rst_n, 1'b1);
`ifdef FEEDER_TIMEOUT_EN
    if (rise_w < 0) begin
      chk("timeout_err_set", timeout_err, 1'b1);
      m_to_err = 1'b1;
      m_cyc_known = 1'b0;
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rec_rst_n", rec_rst_n, 1'b0);
    chk("rst_rec_data_in", rec_data_in, 8'h00);
    chk("rst_result", result, 4'h0);
    chk("rst_result_valid", result_valid, 1'b0);
    chk("rst_cycles", cycles, 32'd0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp image plus a few out-of-range writes that must be dropped.
    for (int i = 0; i < IMG; i++) host_write(i, i & 255);
    for (int i = 0; i < 8; i++) host_write($urandom_range(IMG, 1023), $urandom);
    check_idle("load");

    // Ramp frame, decision 3, write attempted during WAIT_FIN.
    start_frame();
    run_body(W1, 3, 1'b0, -1, 1'b1, -1, -1);
    @(negedge clk);
    check_idle("ramp");

    // Finish held high from GAP, dropped, raised again: only the later edge counts.
    start_frame();
    run_body(10, -1, 1'b1, 3, 1'b0, -1, -1);
    // start during DONE is ignored; start one cycle later is accepted.
    start = 1'b1;
    @(negedge clk);
    chk("start_in_done_ignored", busy, 1'b0);
    chk("start_in_done_rec_rst_n", rec_rst_n, 1'b0);
    start_frame();
    run_body($urandom_range(0, W1), -1, 1'b0, -1, 1'b0, -1, 50);
    @(negedge clk);
    check_idle("b2b");

    // Reset in the middle of the stream, then a complete rerun.
    for (int i = 0; i < 20; i++) host_write($urandom_range(0, IMG - 1), $urandom);
    start_frame();
    run_body(W1, -1, 1'b0, -1, 1'b0, 400, -1);
    @(negedge clk);
    check_idle("after_midrst");
    start_frame();
    run_body($urandom_range(0, W1), -1, 1'b0, -1, 1'b0, -1, -1);
    @(negedge clk);
    check_idle("rerun");

`ifdef FEEDER_TIMEOUT_EN
    start_frame();
    run_body(-1, -1, 1'b0, -1, 1'b0, -1, -1);
    @(negedge clk);
    check_idle("timeout");
    start_frame();
    run_body(5, -1, 1'b0, -1, 1'b0, -1, -1);
    @(negedge clk);
    check_idle("after_timeout");
`endif

    // Random images; first one finishes on the very first WAIT_FIN cycle.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 30; i++) host_write($urandom_range(0, 1023), $urandom);
      start_frame();
      run_body((k == 0) ? 0 : $urandom_range(1, W1), -1, 1'b0, -1, 1'b0, -1, -1);
      @(negedge clk);
      check_idle("random");
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("pix_q_drained", pix_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
